// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator, 1024x768 @ 60 Hz by default.
// Every output is a flop loaded from the decode of the next counter position.
module vga_timing_gen #(
  parameter int H_ADDR = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_ADDR = 768,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 29,
  parameter int CNT_W  = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             hblnk_o,
  output logic             vblnk_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ADDR + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ADDR + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ADDR);
  localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ADDR);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ADDR + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ADDR + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ADDR + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ADDR + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap;
  logic             v_wrap;

  // >= rather than == so an upset counter falls back to 0 on the next enabled edge
  always_comb begin
    h_wrap   = (hcount_q >= H_LAST);
    v_wrap   = (vcount_q >= V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end else begin
      vcount_d = (vcount_q > V_LAST) ? '0 : vcount_q;
    end

    hblnk_d       = (hcount_d >= H_BLNK_BEG);
    vblnk_d       = (vcount_d >= V_BLNK_BEG);
    hsync_d       = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
    vsync_d       = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
    line_start_d  = (hcount_d == '0);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  // Reset state matches the decode of position (0,0), so strobes come up high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (en_i) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hblnk_o       = hblnk_q;
  assign vblnk_o       = vblnk_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size instance plus a shrunken-raster
// instance so whole frames fit in a short run; both share clock, reset and enable.
module tb_vga_timing_gen;

  localparam int CW = 11;
  localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 5;
  localparam int SVA = 6,  SVF = 2, SVS = 3, SVB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [CW-1:0] a_h, a_v, b_h, b_v;
  logic a_hb, a_vb, a_hs, a_vs, a_ls, a_fs;
  logic b_hb, b_vb, b_hs, b_vs, b_ls, b_fs;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .hcount_o(a_h), .vcount_o(a_v), .hblnk_o(a_hb), .vblnk_o(a_vb),
    .hsync_o(a_hs), .vsync_o(a_vs), .line_start_o(a_ls), .frame_start_o(a_fs)
  );

  vga_timing_gen #(
    .H_ADDR(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ADDR(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CNT_W(CW)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .hcount_o(b_h), .vcount_o(b_v), .hblnk_o(b_hb), .vblnk_o(b_vb),
    .hsync_o(b_hs), .vsync_o(b_vs), .line_start_o(b_ls), .frame_start_o(b_fs)
  );

  typedef struct packed {
    logic [27:0] a;
    logic [27:0] b;
  } exp_t;

  exp_t q[$];
  int n_a = 0;
  int n_b = 0;
  int vectors = 0;
  int miscompares = 0;

  // Position is simply the number of enabled edges since reset, modulo the frame size
  function automatic logic [27:0] model(input int n, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vs,
                                        input int vb);
    int ht, vt, pos, x, y;
    logic [CW-1:0] hx, vy;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    pos = n % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    hx  = CW'(x);
    vy  = CW'(y);
    return {hx, vy, (x >= ha), (y >= va),
            (x >= ha + hf) && (x < ha + hf + hs),
            (y >= va + vf) && (y < va + vf + vs),
            (x == 0), (x == 0) && (y == 0)};
  endfunction

  task automatic check(input string nm, input logic [27:0] exp, input logic [27:0] act);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hb,vb,hs,vs,ls,fs=%b expected h=%0d v=%0d flags=%b",
               nm, $time, act[27:17], act[16:6], act[5:0], exp[27:17], exp[16:6], exp[5:0]);
    end
  endtask

  // Drive one cycle's inputs (between edges, so reset assertion is asynchronous),
  // record what the outputs must show before the next edge, then take the edge.
  task automatic step(input logic e, input logic r);
    en    = e;
    rst_n = r;
    if (!r) begin
      n_a = 0;
      n_b = 0;
    end
    q.push_back('{model(n_a, 1024, 24, 136, 160, 768, 3, 6, 29),
                  model(n_b, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)});
    @(posedge clk);
    if (r && e) begin
      n_a++;
      n_b++;
    end
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("dut_default", e.a, {a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs});
        check("dut_small",   e.b, {b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_ls, b_fs});
      end
    end
  end

  initial begin
    int guard;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0);
    repeat (1400) step(1'b1, 1'b1);

    guard = 0;
    while ((n_a % 1344) != 500 && guard < 2000) begin
      step(1'b1, 1'b1);
      guard++;
    end
    if (guard >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL enable_setup: position 500 not reached, at %0d required 500", n_a % 1344);
    end
    repeat (10) step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1);

    repeat (9000) step($urandom_range(0, 7) != 0, 1'b1);

    repeat (2) step(1'b1, 1'b0);
    repeat (1500) step($urandom_range(0, 15) != 0, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
